// File: rtl/fb_pkg.sv
// fb_pkg: shared sizes, state and grant encodings for the
// framebuffer write scheduler.
package fb_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fill_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_FILL
  } gnt_e;

  // y*640 as two shifts, no multiplier
  function automatic logic [ADDR_W-1:0] row_base(
    input logic [8:0] y
  );
    logic [ADDR_W-1:0] yw;
    yw = {10'd0, y};
    return (yw << 9) + (yw << 7);
  endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: two-requester round robin, one-hot grants,
// pointer moves only when both requesters compete.
module fb_rr_arbiter
  import fb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_cpu_i,
  input  logic req_fill_i,
  output logic gnt_cpu_o,
  output logic gnt_fill_o
);

  gnt_e last_q, last_d;

  always_comb begin
    gnt_cpu_o  = 1'b0;
    gnt_fill_o = 1'b0;
    last_d     = last_q;
    if (!reset) begin
      if (req_cpu_i && req_fill_i) begin
        if (last_q == GNT_CPU) begin
          gnt_fill_o = 1'b1;
          last_d     = GNT_FILL;
        end else begin
          gnt_cpu_o = 1'b1;
          last_d    = GNT_CPU;
        end
      end else begin
        gnt_cpu_o  = req_cpu_i;
        gnt_fill_o = req_fill_i;
      end
    end
  end

  // LAST_FILL out of reset so the CPU wins the first tie
  always_ff @(posedge clock) begin
    if (reset) last_q <= GNT_FILL;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares the framebuffer write port between CPU
// stores and a rectangle-fill engine. FB_WR_VBLANK_ONLY_EN gates fill on vblank.
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [9:0]        fill_x,
  input  logic [8:0]        fill_y,
  input  logic [9:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fill_err,
  input  logic              vblank,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              wren_signal
);

  fill_state_e state_q, state_d;

  logic [9:0]        x_q, w_q;
  logic [8:0]        y_q, h_q;
  logic [DATA_W-1:0] color_q;

  logic [9:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q, wren_d;

  logic              fill_req;
  logic              gnt_cpu, gnt_fill;
  logic [ADDR_W-1:0] fill_addr;
  logic [10:0]       x_end;
  logic [9:0]        y_end;
  logic              bad_rect;

`ifdef FB_WR_VBLANK_ONLY_EN
  assign fill_req = (state_q == ST_FILL) && vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign fill_req      = (state_q == ST_FILL);
`endif

  fb_rr_arbiter u_arb (
    .clock      (clock),
    .reset      (reset),
    .req_cpu_i  (cpu_req),
    .req_fill_i (fill_req),
    .gnt_cpu_o  (gnt_cpu),
    .gnt_fill_o (gnt_fill)
  );

  assign x_end    = {1'b0, fill_x} + {1'b0, fill_w};
  assign y_end    = {1'b0, fill_y} + {1'b0, fill_h};
  assign bad_rect = (fill_w == 10'd0) || (fill_h == 9'd0) ||
                    (x_end > 11'(H_RES)) || (y_end > 10'(V_RES));

  assign fill_addr = base_q + ADDR_W'(x_q) + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          if (bad_rect) err_d   = 1'b1;
          else          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        base_d  = row_base(y_q);
        col_d   = 10'd0;
        row_d   = 9'd0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (gnt_fill) begin
          if (col_q == w_q - 10'd1) begin
            col_d  = 10'd0;
            row_d  = row_q + 9'd1;
            base_d = base_q + ADDR_W'(H_RES);
            if (row_q == h_q - 9'd1) state_d = ST_DONE;
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wren_d  = gnt_cpu | gnt_fill;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_cpu) begin
      waddr_d = cpu_addr;
      wdata_d = cpu_data;
    end else if (gnt_fill) begin
      waddr_d = fill_addr;
      wdata_d = color_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (state_q == ST_IDLE && fill_start) begin
      x_q     <= fill_x;
      y_q     <= fill_y;
      w_q     <= fill_w;
      h_q     <= fill_h;
      color_q <= fill_color;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

  assign cpu_ack     = gnt_cpu;
  assign fill_busy   = (state_q == ST_SETUP) || (state_q == ST_FILL);
  assign fill_done   = (state_q == ST_DONE);
  assign fill_err    = err_q;
  assign write_addr  = waddr_q;
  assign write_data  = wdata_q;
  assign wren_signal = wren_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: table, directed and random checks of the
// framebuffer write scheduler against a pixel-queue scoreboard.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_ack;
  logic              fill_start;
  logic [9:0]        fill_x, fill_w;
  logic [8:0]        fill_y, fill_h;
  logic [DATA_W-1:0] fill_color;
  logic              fill_busy, fill_done, fill_err;
  logic              vblank;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              wren_signal;

  fb_write_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ack     (cpu_ack),
    .fill_start  (fill_start),
    .fill_x      (fill_x),
    .fill_y      (fill_y),
    .fill_w      (fill_w),
    .fill_h      (fill_h),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .fill_err    (fill_err),
    .vblank      (vblank),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .wren_signal (wren_signal)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    bit err;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // expected fill pixel addresses, in raster order
  int unsigned fq[$];
  logic [7:0]  fcol;
  bit          src_log[$];
  int          done_cnt = 0;
  int          wr_cnt   = 0;
  bit          prev_ack, prev_wait, last_ack;
  logic [18:0] prev_addr;
  logic [7:0]  prev_data;
  int unsigned exp_a;
  int          cpu_mode = 0;
  bit          vb_rand  = 0;
  int          idx, w0, d0;
  vec_t        tbl[9];

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every write must be the CPU store acked last cycle
  // or the next pixel of the active rectangle
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        fq.delete();
        prev_ack  = 1'b0;
        prev_wait = 1'b0;
        last_ack  = 1'b0;
      end else begin
        if (prev_ack) begin
          chk(wren_signal === 1'b1 && write_addr == prev_addr &&
              write_data == prev_data, "cpu_write", write_addr, prev_addr);
          src_log.push_back(1'b0);
        end else if (wren_signal !== 1'b0) begin
          if (fq.size() == 0) begin
            chk(1'b0, "unexpected_write", write_addr, 0);
          end else begin
            exp_a = fq.pop_front();
            chk(write_addr == exp_a && write_data == fcol,
                "fill_write", write_addr, exp_a);
            src_log.push_back(1'b1);
          end
        end
        if (cpu_req && prev_wait)
          chk(cpu_ack === 1'b1, "cpu_wait_bound", cpu_ack, 1);
        if (cpu_req && !fill_busy)
          chk(cpu_ack === 1'b1, "cpu_idle_grant", cpu_ack, 1);
        if (fill_done === 1'b1) begin
          done_cnt++;
          chk(fq.size() == 0, "done_after_last", fq.size(), 0);
        end
        if (wren_signal === 1'b1) wr_cnt++;
        prev_ack  = (cpu_ack === 1'b1);
        prev_addr = cpu_addr;
        prev_data = cpu_data;
        prev_wait = cpu_req && (cpu_ack !== 1'b1);
        last_ack  = prev_ack;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (cpu_mode == 1) begin
      if (!cpu_req || last_ack) begin
        cpu_req  = ($urandom % 3) != 0;
        cpu_addr = 19'($urandom_range(0, 307199));
        cpu_data = 8'($urandom);
      end
    end else if (cpu_mode == 2) begin
      cpu_req = 1'b1;
      if (last_ack) begin
        cpu_addr = cpu_addr + 19'd7;
        cpu_data = cpu_data + 8'd1;
      end
    end
    if (vb_rand) vblank = 1'($urandom % 2);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_fill(input int x, input int y, input int w,
                            input int h, input logic [7:0] col,
                            input bit exp_err);
    fill_x     = 10'(x);
    fill_y     = 9'(y);
    fill_w     = 10'(w);
    fill_h     = 9'(h);
    fill_color = col;
    fill_start = 1'b1;
    if (!exp_err) begin
      fcol = col;
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          fq.push_back(32'((y + r) * H_RES + x + c));
    end
    step();
    fill_start = 1'b0;
    chk(fill_err === exp_err, "fill_err", fill_err, exp_err);
    chk(fill_busy === !exp_err, "fill_busy", fill_busy, !exp_err);
  endtask

  task automatic wait_done(input int budget);
    int n0, n;
    n0 = done_cnt;
    n  = 0;
    while (done_cnt == n0 && n < budget) begin
      step();
      n++;
    end
    chk(done_cnt == n0 + 1, "fill_done_seen", done_cnt - n0, 1);
    chk(fq.size() == 0, "fill_pixels_left", fq.size(), 0);
    step();
    step();
    chk(done_cnt == n0 + 1 && fill_busy === 1'b0,
        "fill_done_once", done_cnt - n0, 1);
    if (done_cnt != n0 + 1 || fq.size() != 0) apply_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    tbl[0] = '{0,   0,   0,   1,  1};
    tbl[1] = '{630, 0,   20,  1,  1};
    tbl[2] = '{0,   470, 1,   11, 1};
    tbl[3] = '{0,   0,   1,   0,  1};
    tbl[4] = '{639, 0,   2,   1,  1};
    tbl[5] = '{630, 5,   10,  2,  0};
    tbl[6] = '{639, 479, 1,   1,  0};
    tbl[7] = '{0,   0,   640, 1,  0};
    tbl[8] = '{5,   478, 3,   2,  0};

    reset      = 1'b1;
    cpu_req    = 1'b1;
    cpu_addr   = '0;
    cpu_data   = '0;
    fill_start = 1'b0;
    fill_x     = '0;
    fill_y     = '0;
    fill_w     = '0;
    fill_h     = '0;
    fill_color = '0;
    vblank     = 1'b1;

    // reset held with a pending CPU request
    repeat (3) begin
      @(posedge clock);
      #1;
      chk(cpu_ack === 1'b0, "rst_cpu_ack", cpu_ack, 0);
      chk(wren_signal === 1'b0, "rst_wren", wren_signal, 0);
    end
    chk(write_addr === '0 && write_data === '0, "rst_wdata", write_addr, 0);
    chk(fill_busy === 1'b0 && fill_done === 1'b0 && fill_err === 1'b0,
        "rst_flags", {fill_busy, fill_done, fill_err}, 0);

    // CPU only
    cpu_addr = 19'h12345;
    cpu_data = 8'hA5;
    reset    = 1'b0;
    #1;
    chk(cpu_ack === 1'b1, "cpu_ack_same_cycle", cpu_ack, 1);
    step();
    cpu_req = 1'b0;
    chk(wren_signal === 1'b1, "cpu_wren", wren_signal, 1);
    chk(write_addr == 19'h12345, "cpu_addr", write_addr, 19'h12345);
    chk(write_data == 8'hA5, "cpu_data", write_data, 8'hA5);

    // 2x2 fill at (1,1), exact cycle timing
    start_fill(1, 1, 2, 2, 8'h3C, 1'b0);
    step();
    chk(wren_signal === 1'b0 && fill_busy === 1'b1,
        "fill2_first_cycle", wren_signal, 0);
    step();
    chk(wren_signal === 1'b1 && write_addr == 19'd641, "fill2_p0", write_addr, 641);
    step();
    chk(wren_signal === 1'b1 && write_addr == 19'd642, "fill2_p1", write_addr, 642);
    step();
    chk(wren_signal === 1'b1 && write_addr == 19'd1281, "fill2_p2", write_addr, 1281);
    step();
    chk(wren_signal === 1'b1 && write_addr == 19'd1282, "fill2_p3", write_addr, 1282);
    chk(write_data == 8'h3C, "fill2_color", write_data, 8'h3C);
    chk(fill_done === 1'b1 && fill_busy === 1'b0, "fill2_done", fill_done, 1);
    step();
    chk(fill_done === 1'b0 && wren_signal === 1'b0, "fill2_idle", fill_done, 0);

    // contention: 3x1 fill against a CPU that never lets go
    src_log.delete();
    cpu_mode = 2;
    step();
    start_fill(0, 0, 3, 1, 8'h77, 1'b0);
    wait_done(40);
    cpu_mode = 0;
    cpu_req  = 1'b0;
    step();
    step();
    idx = -1;
    foreach (src_log[i]) if (src_log[i] && idx < 0) idx = i;
    chk(idx >= 1 && idx + 4 < src_log.size(), "cont_window", idx, 1);
    if (idx >= 1 && idx + 4 < src_log.size())
      for (int k = 0; k < 6; k++)
        chk(src_log[idx - 1 + k] == bit'(k % 2), "cont_alternate",
            src_log[idx - 1 + k], k % 2);

    // table of fill commands, legal and rejected
    for (int i = 0; i < 9; i++) begin
      start_fill(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h,
                 8'(i * 17 + 3), tbl[i].err);
      if (tbl[i].err) begin
        w0 = wr_cnt;
        repeat (4) step();
        chk(wr_cnt == w0, "err_no_write", wr_cnt - w0, 0);
        chk(fill_busy === 1'b0, "err_not_busy", fill_busy, 0);
      end else begin
        wait_done(tbl[i].w * tbl[i].h * 2 + 20);
      end
    end

    // vblank gating, plus fill_start ignored while busy
    vblank = 1'b0;
    start_fill(10, 10, 4, 3, 8'h5A, 1'b0);
    fill_w     = 10'd0;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    chk(fill_err === 1'b0, "start_ignored_busy", fill_err, 0);
    w0 = wr_cnt;
    repeat (6) step();
`ifdef FB_WR_VBLANK_ONLY_EN
    chk(wr_cnt == w0 && fill_busy === 1'b1, "vblank_pause", wr_cnt - w0, 0);
    vblank = 1'b1;
    step();
    step();
    vblank = 1'b0;
    repeat (4) step();
    chk(wr_cnt - w0 == 2 && fill_busy === 1'b1, "vblank_partial", wr_cnt - w0, 2);
`endif
    vblank = 1'b1;
    wait_done(40);

    // reset in the middle of a fill
    start_fill(100, 200, 6, 4, 8'hC3, 1'b0);
    repeat (5) step();
    chk(fill_busy === 1'b1, "midfill_busy", fill_busy, 1);
    reset = 1'b1;
    step();
    chk(wren_signal === 1'b0 && fill_busy === 1'b0 && fill_done === 1'b0,
        "midfill_reset", {wren_signal, fill_busy, fill_done}, 0);
    reset = 1'b0;
    d0 = done_cnt;
    w0 = wr_cnt;
    repeat (5) step();
    chk(wr_cnt == w0 && done_cnt == d0 && fill_busy === 1'b0,
        "midfill_aborted", wr_cnt - w0, 0);

    // random fills against random CPU traffic and vblank
    cpu_mode = 1;
    vb_rand  = 1;
    for (int k = 0; k < 30; k++) begin
      int x, y, w, h;
      bit e;
      w = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 8);
      h = $urandom_range(0, 4);
      x = ($urandom % 2) ? $urandom_range(628, 639) : $urandom_range(0, 639);
      y = ($urandom % 2) ? $urandom_range(474, 479) : $urandom_range(0, 479);
      e = (w == 0) || (h == 0) || (x + w > H_RES) || (y + h > V_RES);
      start_fill(x, y, w, h, 8'($urandom), e);
      if (e) repeat (3) step();
      else   wait_done(w * h * 8 + 40);
    end
    cpu_mode = 0;
    cpu_req  = 1'b0;
    vb_rand  = 0;
    vblank   = 1'b1;
    repeat (4) step();
    chk(fq.size() == 0 && fill_busy === 1'b0, "final_idle", fq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
